// File: rtl/button_bank_debounce_8.sv
// Eight-channel active-low button debouncer: two-flop synchroniser, per-channel
// saturating counter, registered debounced level plus one-cycle press/release strobes.
// The release strobe port is named `rel` because `release` is a reserved word.
module button_bank_debounce_8 #(
    parameter int unsigned DB_COUNT = 50000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn_raw,
    output logic [7:0] btn_db,
    output logic [7:0] press,
    output logic [7:0] rel,
    output logic       any_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [CNT_W-1:0] cnt      [8];
    logic [CNT_W-1:0] cnt_nxt  [8];
    logic [7:0]       db_nxt;
    logic [7:0]       press_nxt;
    logic [7:0]       rel_nxt;

    // Any sample that agrees with the debounced state discards all progress.
    always_comb begin
        db_nxt    = btn_db;
        press_nxt = '0;
        rel_nxt   = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != btn_db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_nxt[i]    = s2[i];
                    press_nxt[i] = ~s2[i];
                    rel_nxt[i]   = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '1;
            s2     <= '1;
            btn_db <= '1;
            press  <= '0;
            rel    <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= btn_raw;
            s2     <= s1;
            btn_db <= db_nxt;
            press  <= press_nxt;
            rel    <= rel_nxt;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign any_press = |press;

endmodule
